// File: rtl/ram_sync_param.sv
// Parameterised single-port synchronous RAM: registered read with valid strobe, post-reset clear
// sweep, out-of-range detection. Define RAM_PARITY_EN to add per-word even parity and a perr check.
module ram_sync_param #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ADDR_W  = 8,
  parameter int unsigned       DEPTH   = 256,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out,
  output logic              rvalid,
  output logic              busy,
  output logic              err,
  output logic              perr
);

  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CMP_W    = ADDR_W + 1;
  localparam logic [CMP_W-1:0]  DEPTH_C  = CMP_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic                perr_q, perr_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we_c;
  logic [IDX_W-1:0]    mem_widx_c;
  logic [DATA_W-1:0]   mem_wdata_c;

  logic                in_range_c;
  logic [IDX_W-1:0]    idx_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic                rd_perr_c;

  assign in_range_c = ({1'b0, address} < DEPTH_C);
  assign idx_c      = IDX_W'(address);
  assign rd_word_c  = mem_q[idx_c];

  // Sweep writes CLR_VAL once per cycle; IDLE serves requests, read-first on collisions.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    out_d       = out_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    perr_d      = 1'b0;
    mem_we_c    = 1'b0;
    mem_widx_c  = ptr_q;
    mem_wdata_c = CLR_VAL;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c = 1'b1;
        busy_d   = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        if (ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        if (read) begin
          rvalid_d = 1'b1;
          out_d    = in_range_c ? rd_word_c : '0;
          perr_d   = in_range_c & rd_perr_c;
        end
        if ((read || write) && !in_range_c) err_d = 1'b1;
        if (write && in_range_c) begin
          mem_we_c    = 1'b1;
          mem_widx_c  = idx_c;
          mem_wdata_c = data;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      busy_q   <= 1'b1;
      out_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      out_q    <= out_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      perr_q   <= perr_d;
    end
  end

  // Storage has no reset; nothing is written while rst is low.
  always_ff @(posedge clk) begin
    if (rst && mem_we_c) mem_q[mem_widx_c] <= mem_wdata_c;
  end

`ifdef RAM_PARITY_EN
  logic par_q [DEPTH];
  logic par_inj;

  // Test hook: while set, writes store inverted parity.
  task automatic set_par_inj(input logic v);
    par_inj = v;
  endtask

  always_ff @(posedge clk) begin
    if (rst && mem_we_c) par_q[mem_widx_c] <= (^mem_wdata_c) ^ par_inj;
  end

  assign rd_perr_c = par_q[idx_c] ^ (^rd_word_c);
`else
  assign rd_perr_c = 1'b0;
`endif

  assign out    = out_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;
  assign err    = err_q;
  assign perr   = perr_q;

endmodule

// File: tb/tb_ram_sync_param.sv
// Scoreboard bench for ram_sync_param: directed cases plus random traffic against an array model.
module tb_ram_sync_param;

  localparam int unsigned DEPTH   = 200;
  localparam logic [7:0]  CLR_VAL = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       read, write;
  logic [7:0] address, data;
  logic [7:0] out;
  logic       rvalid, busy, err, perr;

  ram_sync_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .CLR_VAL(CLR_VAL)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .address(address), .data(data),
    .out(out), .rvalid(rvalid), .busy(busy), .err(err), .perr(perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rd;
    logic [7:0] dat;
    bit         er;
    bit         pe;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem_m [DEPTH];
  bit         model_busy;
  bit         perr_next;
  int         n_cmp  = 0;
  int         n_fail = 0;

  // Monitor: every rvalid/err presentation must match the oldest expected response.
  exp_t e_mon;
  always @(negedge clk) begin
    if (rvalid === 1'b1 || err === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: got rvalid=%0b err=%0b out=%02h, none expected", rvalid, err, out);
      end else begin
        e_mon = q.pop_front();
        if (rvalid !== e_mon.rd || err !== e_mon.er || perr !== e_mon.pe ||
            (e_mon.rd && out !== e_mon.dat)) begin
          n_fail++;
          $display("FAIL resp: got rvalid=%0b err=%0b perr=%0b out=%02h, want rvalid=%0b err=%0b perr=%0b out=%02h",
                   rvalid, err, perr, out, e_mon.rd, e_mon.er, e_mon.pe, e_mon.dat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Drive one request for one clock; record what the spec says the RAM must answer.
  task automatic issue(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    read = r; write = w; address = a; data = d;
    if (!model_busy) begin
      if (r || (w && a >= DEPTH)) begin
        e.rd  = r;
        e.er  = (a >= DEPTH);
        e.dat = (r && a < DEPTH) ? mem_m[a] : 8'h00;
        e.pe  = r && (a < DEPTH) && perr_next;
        q.push_back(e);
      end
      if (w && a < DEPTH) mem_m[a] = d;
    end
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts busy cycles from release; a request is attempted mid-sweep and must be ignored.
  task automatic sweep_check();
    int cnt = 0;
    model_busy = 1'b1;
    while (busy === 1'b1 && cnt < int'(DEPTH) + 8) begin
      read = 1'b0; write = 1'b0;
      if (cnt == 150) begin
        read = 1'b1; write = 1'b1; address = 8'h10; data = 8'hEE;
      end
      cnt++;
      @(negedge clk);
    end
    read = 1'b0; write = 1'b0;
    check("busy_cycles", 8'(cnt), 8'(DEPTH));
    model_busy = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = CLR_VAL;
  endtask

  task automatic reset_check(input string name);
    check(name, {busy, rvalid, err, perr, 4'h0}, 8'h80);
    check({name, "_out"}, out, 8'h00);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; read = 1'b0; write = 1'b0; address = '0; data = '0;
    model_busy = 1'b1; perr_next = 1'b0;
`ifdef RAM_PARITY_EN
    dut.set_par_inj(1'b0);
`endif
    repeat (3) @(negedge clk);
    reset_check("reset_state");
    rst = 1'b1;
    sweep_check();

    // Cleared contents, then write/read back.
    issue(1, 0, 8'h1F, 8'h00);
    issue(0, 1, 8'h01, 8'hAA);
    issue(0, 1, 8'h0A, 8'hCC);
    issue(1, 0, 8'h01, 8'h00);
    issue(1, 0, 8'h0A, 8'h00);
    issue(1, 0, 8'h10, 8'h00);
    idle(2);

    // Read-first collision.
    issue(0, 1, 8'h05, 8'h11);
    issue(1, 1, 8'h05, 8'h22);
    issue(1, 0, 8'h05, 8'h00);
    issue(1, 1, 8'h06, 8'h33);
    issue(1, 0, 8'h06, 8'h00);
    idle(2);

    // Range boundary.
    issue(0, 1, 8'hC7, 8'h77);
    issue(0, 1, 8'hC8, 8'h55);
    issue(1, 0, 8'hC8, 8'h00);
    issue(1, 0, 8'hC7, 8'h00);
    issue(1, 1, 8'hFF, 8'h99);
    issue(1, 0, 8'h00, 8'h00);
    idle(2);
    check("out_holds", out, mem_m[0]);

    // Parity: corrupt stored bit of word 3 (perr stays 0 when parity is not built in).
`ifdef RAM_PARITY_EN
    dut.set_par_inj(1'b1);
`endif
    issue(0, 1, 8'h03, 8'h0F);
`ifdef RAM_PARITY_EN
    dut.set_par_inj(1'b0);
    perr_next = 1'b1;
`endif
    issue(1, 0, 8'h03, 8'h00);
    perr_next = 1'b0;
    issue(0, 1, 8'h03, 8'h0F);
    issue(1, 0, 8'h03, 8'h00);
    idle(2);

    // Random traffic, including out-of-range addresses and back-to-back requests.
    for (int i = 0; i < 1500; i++) begin
      issue(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom));
      if ($urandom_range(3) == 0) idle(1);
    end
    for (int a = 0; a < int'(DEPTH); a++) issue(1, 0, 8'(a), 8'h00);
    idle(3);
    check("queue_drained", 8'(q.size()), 8'h00);

    // Reset mid-sweep: sweep restarts and runs a full DEPTH cycles.
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    model_busy = 1'b1;
    idle(100);
    rst = 1'b0;
    idle(2);
    reset_check("midsweep_reset");
    rst = 1'b1;
    sweep_check();
    issue(1, 0, 8'h10, 8'h00);
    issue(1, 0, 8'hC7, 8'h00);
    issue(1, 0, 8'h01, 8'h00);
    idle(3);
    check("final_queue_drained", 8'(q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
